// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Pipeline sequencer for the hazards that EX operand forwarding
//            cannot resolve: load-use, taken-branch redirect, multi-cycle EX
//            operations and data-memory wait. It drives per-stage
//            stall/flush/bubble controls and keeps a saturating stall counter.
// Ports    : clk, rst_n              clock, asynchronous active-low reset
//            i_rs1_id/i_rs2_id       ID source registers, with i_rs*_used_id
//            i_rd_ex, i_mem_read_ex  EX destination register / EX is a load
//            i_branch_taken_ex       EX redirect
//            i_mc_start_ex, i_mc_done  multi-cycle op held in EX / result pulse
//            i_dmem_req_mem, i_dmem_ready  MEM outstanding access / completion
//            o_mc_go                 start pulse to the multi-cycle unit
//            o_stall_if/id/ex/mem    hold PC, IF/ID, ID/EX, EX/MEM
//            o_flush_id, o_flush_ex, o_bubble_mem  kill / bubble controls
//            o_state                 00 RUN, 01 MC_BUSY, 10 MEM_WAIT
//            o_stall_cycles          saturating count of o_stall_if cycles
//            o_mc_timeout            sticky multi-cycle timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_rs1_id,
  input  logic [4:0]       i_rs2_id,
  input  logic             i_rs1_used_id,
  input  logic             i_rs2_used_id,
  input  logic [4:0]       i_rd_ex,
  input  logic             i_mem_read_ex,
  input  logic             i_branch_taken_ex,
  input  logic             i_mc_start_ex,
  input  logic             i_mc_done,
  input  logic             i_dmem_req_mem,
  input  logic             i_dmem_ready,
  output logic             o_mc_go,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_stall_mem,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic             o_bubble_mem,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic             o_mc_timeout
);

  localparam int TMR_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] C_TMR_LIMIT = TMR_W'(MC_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MC_BUSY  = 2'b01,
    S_MEM_WAIT = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             r_mc_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_set_timeout;

  logic w_freeze;
  logic w_lu;
  logic w_mc_go;
  logic w_stall_if;
  logic w_stall_id;
  logic w_stall_ex;
  logic w_stall_mem;
  logic w_flush_id;
  logic w_flush_ex;
  logic w_bubble_mem;

  assign w_freeze = i_dmem_req_mem & ~i_dmem_ready;

  assign w_lu = i_mem_read_ex & (i_rd_ex != 5'd0) &
                ((i_rs1_used_id & (i_rs1_id == i_rd_ex)) |
                 (i_rs2_used_id & (i_rs2_id == i_rd_ex)));

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_set_timeout = 1'b0;
    w_mc_go       = 1'b0;
    w_stall_if    = 1'b0;
    w_stall_id    = 1'b0;
    w_stall_ex    = 1'b0;
    w_stall_mem   = 1'b0;
    w_flush_id    = 1'b0;
    w_flush_ex    = 1'b0;
    w_bubble_mem  = 1'b0;

    case (r_state)
      // MEM_WAIT decodes exactly like RUN once the freeze lifts, so any
      // branch, load-use or multi-cycle start held in EX is acted on then.
      S_RUN, S_MEM_WAIT: begin
        if (w_freeze) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_stall_mem = 1'b1;
          w_state_nxt = S_MEM_WAIT;
        end else begin
          w_state_nxt = S_RUN;
          if (i_mc_start_ex) begin
            w_mc_go = 1'b1;
            // A same-cycle completion needs no wait at all.
            if (!i_mc_done) begin
              w_stall_if   = 1'b1;
              w_stall_id   = 1'b1;
              w_stall_ex   = 1'b1;
              w_bubble_mem = 1'b1;
              w_state_nxt  = S_MC_BUSY;
              w_timer_nxt  = TMR_W'(1);
            end
          end else if (i_branch_taken_ex) begin
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
          end else if (w_lu) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
          end
        end
      end

      S_MC_BUSY: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if (w_freeze) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_stall_mem = 1'b1;
        end else if (!i_mc_done && (r_timer != C_TMR_LIMIT)) begin
          w_stall_if   = 1'b1;
          w_stall_id   = 1'b1;
          w_stall_ex   = 1'b1;
          w_bubble_mem = 1'b1;
        end
        // The done pulse is consumed even while frozen; EX is held so the
        // captured result is not lost.
        if (i_mc_done) begin
          w_state_nxt = S_RUN;
          w_timer_nxt = '0;
        end else if (r_timer == C_TMR_LIMIT) begin
          w_set_timeout = 1'b1;
          w_state_nxt   = S_RUN;
          w_timer_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_RUN;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_RUN;
      r_timer        <= '0;
      r_mc_timeout   <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      if (w_set_timeout) begin
        r_mc_timeout <= 1'b1;
      end
      if (w_stall_if && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  // Controls are forced low while reset is held so a pending multi-cycle
  // start is not re-issued and no stage is stalled or flushed.
  assign o_mc_go        = rst_n & w_mc_go;
  assign o_stall_if     = rst_n & w_stall_if;
  assign o_stall_id     = rst_n & w_stall_id;
  assign o_stall_ex     = rst_n & w_stall_ex;
  assign o_stall_mem    = rst_n & w_stall_mem;
  assign o_flush_id     = rst_n & w_flush_id;
  assign o_flush_ex     = rst_n & w_flush_ex;
  assign o_bubble_mem   = rst_n & w_bubble_mem;
  assign o_state        = r_state;
  assign o_stall_cycles = r_stall_cycles;
  assign o_mc_timeout   = r_mc_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Self-checking bench for hazard_stall_ctrl: directed hazard
//            scenarios followed by randomized stimulus, all compared against
//            a behavioural model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int C_TO   = 8;
  localparam int C_CW   = 6;
  localparam int C_CMAX = (1 << C_CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [4:0]      i_rs1_id, i_rs2_id, i_rd_ex;
  logic            i_rs1_used_id, i_rs2_used_id, i_mem_read_ex, i_branch_taken_ex;
  logic            i_mc_start_ex, i_mc_done, i_dmem_req_mem, i_dmem_ready;
  logic            o_mc_go, o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic            o_flush_id, o_flush_ex, o_bubble_mem, o_mc_timeout;
  logic [1:0]      o_state;
  logic [C_CW-1:0] o_stall_cycles;
  logic [7:0]      w_dut_ctl;

  hazard_stall_ctrl #(.MC_TIMEOUT(C_TO), .CNT_W(C_CW)) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_rs1_id          (i_rs1_id),
    .i_rs2_id          (i_rs2_id),
    .i_rs1_used_id     (i_rs1_used_id),
    .i_rs2_used_id     (i_rs2_used_id),
    .i_rd_ex           (i_rd_ex),
    .i_mem_read_ex     (i_mem_read_ex),
    .i_branch_taken_ex (i_branch_taken_ex),
    .i_mc_start_ex     (i_mc_start_ex),
    .i_mc_done         (i_mc_done),
    .i_dmem_req_mem    (i_dmem_req_mem),
    .i_dmem_ready      (i_dmem_ready),
    .o_mc_go           (o_mc_go),
    .o_stall_if        (o_stall_if),
    .o_stall_id        (o_stall_id),
    .o_stall_ex        (o_stall_ex),
    .o_stall_mem       (o_stall_mem),
    .o_flush_id        (o_flush_id),
    .o_flush_ex        (o_flush_ex),
    .o_bubble_mem      (o_bubble_mem),
    .o_state           (o_state),
    .o_stall_cycles    (o_stall_cycles),
    .o_mc_timeout      (o_mc_timeout)
  );

  // {go, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, bubble_mem}
  assign w_dut_ctl = {o_mc_go, o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
                      o_flush_id, o_flush_ex, o_bubble_mem};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0 run, 1 waiting on multi-cycle unit, 2 memory wait.
  int         m_mode;
  int         m_age;   // cycles spent waiting on the multi-cycle unit, 1-based
  int         m_cnt;
  bit         m_to;
  logic [7:0] exp_ctl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_ctl();
    bit frz, lu, hit1, hit2;
    logic [7:0] c;
    c    = 8'h00;
    frz  = i_dmem_req_mem && !i_dmem_ready;
    hit1 = i_rs1_used_id && (i_rs1_id == i_rd_ex);
    hit2 = i_rs2_used_id && (i_rs2_id == i_rd_ex);
    lu   = i_mem_read_ex && (i_rd_ex != 0) && (hit1 || hit2);
    if (frz) begin
      c = 8'b0111_1000;                           // all four stalls
    end else if (m_mode == 1) begin
      if (!i_mc_done && m_age != C_TO) c = 8'b0111_0001;
    end else if (i_mc_start_ex) begin
      c = i_mc_done ? 8'b1000_0000 : 8'b1111_0001;
    end else if (i_branch_taken_ex) begin
      c = 8'b0000_0110;
    end else if (lu) begin
      c = 8'b0110_0010;
    end
    return c;
  endfunction

  task automatic check_now();
    #1;
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_cnt = 0; m_to = 1'b0;
    end
    exp_ctl = rst_n ? model_ctl() : 8'h00;
    chk("ctl",     w_dut_ctl,      exp_ctl);
    chk("state",   o_state,        m_mode);
    chk("cnt",     o_stall_cycles, m_cnt);
    chk("timeout", o_mc_timeout,   m_to);
  endtask

  task automatic tick();
    bit frz;
    @(posedge clk);
    if (rst_n) begin
      frz = i_dmem_req_mem && !i_dmem_ready;
      if (m_mode == 1) begin
        if (i_mc_done || m_age == C_TO) begin
          if (!i_mc_done) m_to = 1'b1;
          m_mode = 0;
          m_age  = 0;
        end else begin
          m_age++;
        end
      end else if (frz) begin
        m_mode = 2;
      end else if (i_mc_start_ex && !i_mc_done) begin
        m_mode = 1;
        m_age  = 1;
      end else begin
        m_mode = 0;
      end
      if (exp_ctl[6]) m_cnt = (m_cnt >= C_CMAX) ? C_CMAX : m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic clear_in();
    i_rs1_id = 0; i_rs2_id = 0; i_rd_ex = 0;
    i_rs1_used_id = 0; i_rs2_used_id = 0; i_mem_read_ex = 0; i_branch_taken_ex = 0;
    i_mc_start_ex = 0; i_mc_done = 0; i_dmem_req_mem = 0; i_dmem_ready = 0;
  endtask

  initial begin
    m_mode = 0; m_age = 0; m_cnt = 0; m_to = 1'b0; exp_ctl = 8'h00;
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    check_now(); tick();
    check_now(); tick();
    rst_n = 1'b1;

    // Load-use: one stall cycle, then released once the load leaves EX.
    i_rd_ex = 5; i_mem_read_ex = 1; i_rs1_id = 5; i_rs1_used_id = 1;
    check_now();
    chk("lu_stall", {o_stall_if, o_stall_id, o_flush_ex}, 3'b111);
    tick();
    i_mem_read_ex = 0;
    check_now();
    chk("lu_release", {o_stall_if, o_stall_id, o_flush_ex}, 3'b000);
    tick();

    // No hazard when rd is x0 or the source is unused.
    i_mem_read_ex = 1; i_rd_ex = 0; i_rs1_id = 0;
    check_now();
    chk("lu_rd0", o_stall_if, 1'b0);
    tick();
    i_rd_ex = 5; i_rs1_id = 5; i_rs1_used_id = 0;
    check_now();
    chk("lu_unused", o_stall_if, 1'b0);
    tick();
    check_now();
    chk("lu_cnt", o_stall_cycles, 1);

    // Branch beats load-use.
    i_rs1_used_id = 1; i_branch_taken_ex = 1;
    check_now();
    chk("br_flush", {o_flush_id, o_flush_ex}, 2'b11);
    chk("br_nostall", o_stall_if, 1'b0);
    tick();
    clear_in();

    // Multi-cycle op: go once, six waiting cycles, done on the sixth.
    i_mc_start_ex = 1;
    check_now();
    chk("mc_go", o_mc_go, 1'b1);
    tick();
    for (int k = 1; k <= 6; k++) begin
      i_mc_done = (k == 6);
      check_now();
      chk("mc_busy", o_state, 2'b01);
      chk("mc_go_once", o_mc_go, 1'b0);
      tick();
    end
    clear_in();
    check_now();
    chk("mc_cnt", o_stall_cycles, 7);
    chk("mc_back_run", o_state, 2'b00);
    tick();

    // Timeout with no done pulse.
    i_mc_start_ex = 1;
    check_now(); tick();
    for (int k = 1; k <= C_TO; k++) begin
      if (k == C_TO) i_mc_start_ex = 0;
      check_now();
      if (k == C_TO) chk("to_release", o_stall_if, 1'b0);
      tick();
    end
    check_now();
    chk("to_flag", o_mc_timeout, 1'b1);
    chk("to_state", o_state, 2'b00);
    tick();
    check_now(); tick();
    check_now();
    chk("to_sticky", o_mc_timeout, 1'b1);
    tick();

    // Memory wait defers the branch flush.
    i_dmem_req_mem = 1; i_dmem_ready = 0; i_branch_taken_ex = 1;
    for (int k = 0; k < 3; k++) begin
      check_now();
      chk("frz_stall", {o_stall_if, o_stall_id, o_stall_ex, o_stall_mem}, 4'hf);
      chk("frz_noflush", {o_flush_id, o_flush_ex}, 2'b00);
      tick();
    end
    i_dmem_ready = 1;
    check_now();
    chk("frz_exit_flush", {o_flush_id, o_flush_ex}, 2'b11);
    tick();
    clear_in();

    // Reset while waiting on the multi-cycle unit.
    i_mc_start_ex = 1;
    check_now(); tick();
    check_now(); tick();
    rst_n = 1'b0;
    check_now();
    chk("rst_state", o_state, 2'b00);
    chk("rst_ctl", w_dut_ctl, 8'h00);
    chk("rst_to", o_mc_timeout, 1'b0);
    tick();
    clear_in();
    rst_n = 1'b1;

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      i_rd_ex           = 5'($urandom_range(0, 7));
      i_rs1_id          = 5'($urandom_range(0, 7));
      i_rs2_id          = 5'($urandom_range(0, 7));
      i_rs1_used_id     = 1'($urandom_range(0, 1));
      i_rs2_used_id     = 1'($urandom_range(0, 1));
      i_mem_read_ex     = 1'($urandom_range(0, 1));
      i_branch_taken_ex = ($urandom_range(0, 3) == 0);
      i_mc_start_ex     = ($urandom_range(0, 5) == 0);
      i_mc_done         = ($urandom_range(0, 9) == 0);
      i_dmem_req_mem    = ($urandom_range(0, 3) == 0);
      i_dmem_ready      = 1'($urandom_range(0, 1));
      rst_n             = ($urandom_range(0, 299) != 0);
      check_now();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
